square_wave_period_meter: RTL and testbench

//   Receive-side companion to square_wave: takes a sampled multi-bit square wave,

---
 rtl/square_wave_period_meter.sv | 121 ++++++++++++
 tb/tb_square_wave_period_meter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/square_wave_period_meter.sv
// Square-wave period meter: hysteresis slicer on a sampled wave, then an FSM that
// times rising-edge-to-rising-edge period and high time, with loss-of-signal timeout.
module square_wave_period_meter #(
  parameter int resolution_bits = 8,
  parameter int counter_width   = 16,
  parameter int thresh_hi       = 160,
  parameter int thresh_lo       = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [resolution_bits-1:0] square_in,
  output logic [counter_width-1:0]   period_out,
  output logic [counter_width-1:0]   high_out,
  output logic                       measure_valid,
  output logic                       locked,
  output logic                       timeout
);

  // state   | meaning
  // SEEK    | waiting for the first rising edge, counter parked at 0
  // MEASURE | counting cycles since the last rising edge
  // TIMEOUT | no rising edge for a full counter span; last results held

  typedef enum logic [1:0] {SEEK, MEASURE, TIMEOUT} state_t;

  localparam logic [resolution_bits-1:0] TH_HI   = resolution_bits'(thresh_hi);
  localparam logic [resolution_bits-1:0] TH_LO   = resolution_bits'(thresh_lo);
  localparam logic [counter_width-1:0]   CNT_MAX = '1;
  localparam logic [counter_width-1:0]   CNT_ONE = counter_width'(1);

  state_t                     state, state_nxt;
  logic [resolution_bits-1:0] s_reg;
  logic                       lvl, lvl_nxt;
  logic                       rise, fall;
  logic [counter_width-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [counter_width-1:0]   hi_lat, hi_lat_nxt;
  logic [counter_width-1:0]   period_nxt, high_nxt;
  logic                       valid_nxt, locked_nxt, timeout_nxt;

  // Between the thresholds the slicer keeps its previous decision.
  always_comb begin
    lvl_nxt = lvl;
    if (s_reg >= TH_HI)      lvl_nxt = 1'b1;
    else if (s_reg <= TH_LO) lvl_nxt = 1'b0;
  end

  assign rise    = !lvl && lvl_nxt;
  assign fall    = lvl && !lvl_nxt;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_lat_nxt  = hi_lat;
    period_nxt  = period_out;
    high_nxt    = high_out;
    valid_nxt   = 1'b0;
    locked_nxt  = locked;
    timeout_nxt = timeout;
    case (state)
      SEEK: begin
        cnt_nxt = '0;
        if (rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_ONE;
        end
      end
      MEASURE: begin
        cnt_nxt = cnt_inc;
        if (fall) hi_lat_nxt = cnt;
        // A rise on the saturating cycle still counts as a valid measurement.
        if (rise) begin
          period_nxt = cnt;
          high_nxt   = hi_lat;
          valid_nxt  = 1'b1;
          locked_nxt = 1'b1;
          cnt_nxt    = CNT_ONE;
        end else if (cnt_inc == CNT_MAX) begin
          state_nxt   = TIMEOUT;
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
        end
      end
      TIMEOUT: begin
        if (rise) begin
          state_nxt   = MEASURE;
          cnt_nxt     = CNT_ONE;
          timeout_nxt = 1'b0;
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SEEK;
      s_reg         <= '0;
      lvl           <= 1'b0;
      cnt           <= '0;
      hi_lat        <= '0;
      period_out    <= '0;
      high_out      <= '0;
      measure_valid <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_nxt;
      s_reg         <= square_in;
      lvl           <= lvl_nxt;
      cnt           <= cnt_nxt;
      hi_lat        <= hi_lat_nxt;
      period_out    <= period_nxt;
      high_out      <= high_nxt;
      measure_valid <= valid_nxt;
      locked        <= locked_nxt;
      timeout       <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Bench for square_wave_period_meter (counter_width=8): directed and random waves checked
// every cycle against an edge-timestamp model of the meter.
module tb_square_wave_period_meter;

  localparam int RB   = 8;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int THI  = 160;
  localparam int TLO  = 96;

  logic          clk = 1'b0;
  logic          reset;
  logic [RB-1:0] square_in;
  logic [CW-1:0] period_out, high_out;
  logic          measure_valid, locked, timeout;

  int checks   = 0;
  int failures = 0;

  square_wave_period_meter #(
    .resolution_bits(RB), .counter_width(CW), .thresh_hi(THI), .thresh_lo(TLO)
  ) dut (
    .clk(clk), .reset(reset), .square_in(square_in),
    .period_out(period_out), .high_out(high_out),
    .measure_valid(measure_valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: slicer level plus timestamps of edges; outputs are derived from edge times.
  int m_lvl, m_meas, last_rise, last_fall, t;
  int exp_period, exp_high, exp_valid, exp_locked, exp_timeout;

  task automatic model_reset();
    m_lvl = 0; m_meas = 0; last_rise = 0; last_fall = 0;
    exp_period = 0; exp_high = 0; exp_valid = 0; exp_locked = 0; exp_timeout = 0;
  endtask

  // Sample x was captured at edge tt-1, so its edge takes effect at edge tt.
  task automatic model_step(input int x, input int tt);
    int nl;
    nl = (x >= THI) ? 1 : (x <= TLO) ? 0 : m_lvl;
    exp_valid = 0;
    if (m_lvl == 0 && nl == 1) begin
      if (m_meas == 1) begin
        exp_period = tt - last_rise;
        exp_high   = last_fall - last_rise;
        exp_valid  = 1;
        exp_locked = 1;
      end else begin
        m_meas      = 1;
        exp_timeout = 0;
      end
      last_rise = tt;
    end else begin
      if (m_lvl == 1 && nl == 0 && m_meas == 1) last_fall = tt;
      if (m_meas == 1 && (tt - last_rise + 1) == MAXC) begin
        m_meas      = 0;
        exp_timeout = 1;
        exp_locked  = 0;
      end
    end
    m_lvl = nl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s at t=%0d: observed %0d expected %0d", tag, t, obs, expv);
    end
  endtask

  task automatic chk_all();
    chk("period_out",    32'(period_out),    32'(exp_period));
    chk("high_out",      32'(high_out),      32'(exp_high));
    chk("measure_valid", 32'(measure_valid), 32'(exp_valid));
    chk("locked",        32'(locked),        32'(exp_locked));
    chk("timeout",       32'(timeout),       32'(exp_timeout));
  endtask

  task automatic drive(input int v);
    square_in = RB'(v);
    @(posedge clk);
    t++;
    #1;
    chk_all();
    model_step(v, t + 1);
  endtask

  task automatic drive_n(input int v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic wave(input int hi_n, input int lo_n, input int reps);
    for (int r = 0; r < reps; r++) begin
      drive_n(255, hi_n);
      drive_n(0, lo_n);
    end
  endtask

  task automatic pulse_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all();
    @(posedge clk);
    t++;
    #1;
    reset = 1'b0;
    chk_all();
  endtask

  initial begin
    t = 0;
    model_reset();
    reset     = 1'b1;
    square_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    reset = 1'b0;

    // 10/10 wave, then 3/7 duty
    wave(10, 10, 6);
    wave(3, 7, 6);

    // Hysteresis: mid-band never toggles, crossing each threshold does
    for (int i = 0; i < 10; i++) begin
      drive(0);
      drive(128);
    end
    drive_n(128, 3);
    drive_n(200, 4);
    drive_n(120, 4);
    drive_n(90, 4);
    wave(10, 10, 4);

    // Loss of signal, then resume
    drive_n(0, 300);
    wave(10, 10, 4);

    // Period change 20 -> 6
    wave(10, 10, 3);
    wave(3, 3, 6);

    // Reset mid-period while locked
    wave(10, 10, 3);
    drive_n(255, 4);
    pulse_reset();
    drive_n(255, 6);
    wave(10, 10, 4);

    // Random waves with mid-band samples sprinkled into each phase
    for (int p = 0; p < 60; p++) begin
      int hn, ln;
      hn = $urandom_range(1, 12);
      ln = $urandom_range(1, 12);
      drive($urandom_range(THI, 255));
      for (int i = 1; i < hn; i++)
        drive(($urandom_range(0, 3) == 0) ? $urandom_range(TLO + 1, THI - 1)
                                          : $urandom_range(THI, 255));
      drive($urandom_range(0, TLO));
      for (int i = 1; i < ln; i++)
        drive(($urandom_range(0, 3) == 0) ? $urandom_range(TLO + 1, THI - 1)
                                          : $urandom_range(0, TLO));
      if (p == 30) drive_n($urandom_range(0, TLO), 260);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
